// File: rtl/fxp_signal_stage_if.sv
// Streaming bus for the Q16.16 signal-to-position stage: input samples upstream,
// shaped position and flags downstream, each side with its own valid/ready pair.
interface fxp_signal_stage_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] trend_i;
  logic signed [31:0] z_i;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] pos_o;
  logic               clamped_o;
  logic               dead_o;
  logic               flip_o;

  // The stage itself: consumes samples, produces positions.
  modport slave (
    input  in_valid, trend_i, z_i, out_ready,
    output in_ready, out_valid, pos_o, clamped_o, dead_o, flip_o
  );

  // The environment around the stage: feeds samples, drains positions.
  modport master (
    output in_valid, trend_i, z_i, out_ready,
    input  in_ready, out_valid, pos_o, clamped_o, dead_o, flip_o
  );
endinterface

// File: rtl/fxp_signal_stage.sv
// Q16.16 signal-to-position stage: weighted trend/z score, half gain, clamp,
// deadband and sign-flip tracking over a 3-deep stall-together pipeline.
module fxp_signal_stage #(
  parameter int                 CNT_W   = 16,
  parameter logic signed [31:0] LIMIT_Q = 32'sd131072,
  parameter logic signed [31:0] EPS_Q   = 32'sd655
) (
  input  logic                 clk,
  input  logic                 rst,
  fxp_signal_stage_if.slave    bus,
  input  logic                 clr_cnt_i,
  output logic [CNT_W-1:0]     clamp_cnt_o
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam int STAGES = 3;

  // Score weights: WT = 0.75, WZ = 0.25 in Q16.16.
  localparam logic signed [COEF_W-1:0] WT_Q = 32'sd49152;
  localparam logic signed [COEF_W-1:0] WZ_Q = 32'sd16384;

  typedef enum logic [1:0] {
    SGN_NONE = 2'd0,
    SGN_POS  = 2'd1,
    SGN_NEG  = 2'd2
  } sign_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] pos;
    logic                     clamped;
    logic                     dead;
  } shape_t;

  // Q16.16 product with floor rounding: full 64-bit product, arithmetic >>> 16.
  function automatic logic signed [DATA_W-1:0] mul_q16(
    input logic signed [COEF_W-1:0] c,
    input logic signed [DATA_W-1:0] x
  );
    logic signed [DATA_W+COEF_W-1:0] cw;
    logic signed [DATA_W+COEF_W-1:0] xw;
    logic signed [DATA_W+COEF_W-1:0] p;
    cw = (DATA_W+COEF_W)'(c);
    xw = (DATA_W+COEF_W)'(x);
    p  = cw * xw;
    return p[DATA_W+15:16];
  endfunction

  // Saturate to +/-LIMIT_Q (boundary not clamped), then zero the open deadband.
  function automatic shape_t shape_pos(input logic signed [DATA_W-1:0] p);
    shape_t s;
    s.pos     = p;
    s.clamped = 1'b0;
    s.dead    = 1'b0;
    if (p > LIMIT_Q) begin
      s.pos     = LIMIT_Q;
      s.clamped = 1'b1;
    end else if (p < -LIMIT_Q) begin
      s.pos     = -LIMIT_Q;
      s.clamped = 1'b1;
    end else if ((p > -EPS_Q) && (p < EPS_Q)) begin
      s.pos  = '0;
      s.dead = 1'b1;
    end
    return s;
  endfunction

  logic en;

  logic                     vld_p1_q, vld_p2_q, vld_p3_q;
  logic signed [DATA_W-1:0] tw_p1_q, zw_p1_q;
  logic signed [DATA_W-1:0] pos_p2_q;
  logic signed [DATA_W-1:0] pos_p3_q, pos_p3_d;
  logic                     clamped_p3_q, clamped_p3_d;
  logic                     dead_p3_q, dead_p3_d;
  logic                     flip_p3_q, flip_p3_d;
  sign_e                    last_sign_q, last_sign_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic signed [DATA_W:0]   score_p1;
  shape_t                   shp_p2;
  sign_e                    new_sign;

  // Every stage moves together; a held output freezes the whole pipe.
  assign en          = !vld_p3_q || bus.out_ready;
  assign bus.in_ready = en;

  // ---- S1 -> S2 boundary: weighted sum, 33-bit so it never wraps ----
  assign score_p1 = {tw_p1_q[DATA_W-1], tw_p1_q} + {zw_p1_q[DATA_W-1], zw_p1_q};

  // ---- S2 -> S3 boundary: shaping and sign tracking ----
  always_comb begin
    shp_p2       = shape_pos(pos_p2_q);
    new_sign     = SGN_NONE;
    last_sign_d  = last_sign_q;
    flip_p3_d    = 1'b0;
    pos_p3_d     = '0;
    clamped_p3_d = 1'b0;
    dead_p3_d    = 1'b0;
    if (vld_p2_q) begin
      pos_p3_d     = shp_p2.pos;
      clamped_p3_d = shp_p2.clamped;
      dead_p3_d    = shp_p2.dead;
      if (shp_p2.pos != '0) begin
        new_sign    = shp_p2.pos[DATA_W-1] ? SGN_NEG : SGN_POS;
        flip_p3_d   = (last_sign_q != SGN_NONE) && (new_sign != last_sign_q);
        last_sign_d = new_sign;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (vld_p3_q && bus.out_ready && clamped_p3_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath stages S1/S2 carry no reset; their valids gate everything downstream.
  always_ff @(posedge clk) begin
    if (en) begin
      tw_p1_q  <= mul_q16(WT_Q, bus.trend_i);
      zw_p1_q  <= mul_q16(WZ_Q, bus.z_i);
      pos_p2_q <= score_p1[DATA_W:1];
    end
  end

  // ---- S3: control, outputs and counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      pos_p3_q     <= '0;
      clamped_p3_q <= 1'b0;
      dead_p3_q    <= 1'b0;
      flip_p3_q    <= 1'b0;
      last_sign_q  <= SGN_NONE;
      cnt_q        <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        vld_p1_q     <= bus.in_valid;
        vld_p2_q     <= vld_p1_q;
        vld_p3_q     <= vld_p2_q;
        pos_p3_q     <= pos_p3_d;
        clamped_p3_q <= clamped_p3_d;
        dead_p3_q    <= dead_p3_d;
        flip_p3_q    <= flip_p3_d;
        last_sign_q  <= last_sign_d;
      end
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.pos_o     = pos_p3_q;
  assign bus.clamped_o = clamped_p3_q;
  assign bus.dead_o    = dead_p3_q;
  assign bus.flip_o    = flip_p3_q;
  assign clamp_cnt_o   = cnt_q;

  if (STAGES != 3) begin : g_stage_guard
    $error("fxp_signal_stage is built as exactly three stages");
  end

endmodule

// File: tb/tb_fxp_signal_stage.sv
// Bench for fxp_signal_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a plain-arithmetic model of the stage.
module tb_fxp_signal_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_cnt;
  logic [15:0] clamp_cnt;

  fxp_signal_stage_if bus();

  fxp_signal_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clr_cnt_i   (clr_cnt),
    .clamp_cnt_o (clamp_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int pos;
    bit clamped;
    bit dead;
  } exp_t;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input int trend, input int z);
    exp_t   e;
    longint score, p;
    score = fdiv(longint'(trend) * 3, 4) + fdiv(longint'(z), 4);
    p     = fdiv(score, 2);
    e.clamped = 0;
    e.dead    = 0;
    if (p > 131072)       begin e.pos = 131072;  e.clamped = 1; end
    else if (p < -131072) begin e.pos = -131072; e.clamped = 1; end
    else if (p > -655 && p < 655) begin e.pos = 0; e.dead = 1; end
    else e.pos = int'(p);
    return e;
  endfunction

  exp_t q[$];
  int   m_last = 0;
  int   m_cnt  = 0;
  int   n_out  = 0;
  bit   hold_prev = 0;
  int   prev_pos;
  bit   prev_cl, prev_dd, prev_fl;

  always @(negedge clk) begin
    exp_t e;
    int   sg;
    bit   ef;
    if (rst) begin
      q.delete();
      m_last    = 0;
      m_cnt     = 0;
      hold_prev = 0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_pos", bus.pos_o, 0);
      check("rst_flags", {bus.clamped_o, bus.dead_o, bus.flip_o}, 0);
      check("rst_cnt", clamp_cnt, 0);
    end else begin
      check("clamp_cnt", clamp_cnt, m_cnt);
      if (hold_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_pos", bus.pos_o, prev_pos);
        check("hold_flags", {bus.clamped_o, bus.dead_o, bus.flip_o}, {prev_cl, prev_dd, prev_fl});
      end
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_pos  = bus.pos_o;
      prev_cl   = bus.clamped_o;
      prev_dd   = bus.dead_o;
      prev_fl   = bus.flip_o;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e  = q.pop_front();
          ef = 0;
          if (e.pos != 0) begin
            sg = (e.pos < 0) ? -1 : 1;
            ef = (m_last != 0) && (sg != m_last);
            m_last = sg;
          end
          check("model_pos", bus.pos_o, e.pos);
          check("model_clamped", bus.clamped_o, e.clamped);
          check("model_dead", bus.dead_o, e.dead);
          check("model_flip", bus.flip_o, ef);
        end
      end
      if (clr_cnt) m_cnt = 0;
      else if (bus.out_valid && bus.out_ready && bus.clamped_o && m_cnt != 65535) m_cnt++;
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.trend_i, bus.z_i));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int trend, input int z);
    bus.in_valid = 1;
    bus.trend_i  = trend;
    bus.z_i      = z;
    tick();
    bus.in_valid = 0;
  endtask

  task automatic expect_out(input string name, input int pos, input bit cl, input bit dd,
                            input bit fl, input int lat);
    int n   = 0;
    bit got = 0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) got = 1;
    end
    check({name, "_valid"}, got, 1);
    if (got) begin
      if (lat >= 0) check({name, "_latency"}, n, lat);
      check({name, "_pos"}, bus.pos_o, pos);
      check({name, "_clamped"}, bus.clamped_o, cl);
      check({name, "_dead"}, bus.dead_o, dd);
      check({name, "_flip"}, bus.flip_o, fl);
    end
    tick();
  endtask

  int T5_TR[8] = '{65536, -65536, 300000, -400000, 1000, 0, 524288, -70000};
  int T5_Z [8] = '{0, 131072, -50000, 5240, -1, 5240, 262144, -9000};

  initial begin
    int i, c, stalls, out0, k;
    bit acc, found;
    rst = 1; clr_cnt = 0;
    bus.in_valid = 0; bus.out_ready = 1; bus.trend_i = 0; bus.z_i = 0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    tick();
    rst = 0;
    tick();

    // T1..T4 with literal expectations
    send(65536, 0);          expect_out("t1", 24576, 0, 0, 0, 3);
    send(524288, 0);         expect_out("t2a", 131072, 1, 0, 0, -1);
    send(262144, 262144);    expect_out("t2b", 131072, 0, 0, 0, -1);
    send(-524288, 0);        expect_out("t3", -131072, 1, 0, 1, -1);
    @(negedge clk); check("t3_clamp_cnt", clamp_cnt, 2); tick();
    send(1000, 0);           expect_out("t4a", 0, 0, 1, 0, -1);
    send(-1, 0);             expect_out("t4b", 0, 0, 1, 0, -1);
    send(0, 5240);           expect_out("eps_pos", 655, 0, 0, 1, -1);
    send(0, -5240);          expect_out("eps_neg", -655, 0, 0, 1, -1);
    send(0, 5236);           expect_out("eps_in", 0, 0, 1, 0, -1);
    send(0, -5236);          expect_out("floor_neg", -655, 0, 0, 0, -1);

    // T5: back-to-back stream with four cycles of downstream backpressure
    out0 = n_out; i = 0; c = 0; stalls = 0;
    while (i < 8 && c < 100) begin
      bus.in_valid  = 1;
      bus.trend_i   = T5_TR[i];
      bus.z_i       = T5_Z[i];
      bus.out_ready = !(c >= 3 && c < 7);
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) stalls++;
      tick();
      if (acc) i++;
      c++;
    end
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (8) tick();
    check("t5_accepted", i, 8);
    check("t5_stalls_seen", stalls > 0, 1);
    check("t5_delivered", n_out - out0, 8);
    check("t5_queue_empty", q.size(), 0);

    // T6a: reset with three samples in flight
    bus.out_ready = 0;
    bus.in_valid  = 1; bus.trend_i = 300000; bus.z_i = 0;
    repeat (3) tick();
    bus.in_valid = 0;
    check("t6_inflight_valid", bus.out_valid, 1);
    rst = 1;
    #1;
    check("t6_async_valid", bus.out_valid, 0);
    check("t6_async_pos", bus.pos_o, 0);
    repeat (2) tick();
    rst = 0; bus.out_ready = 1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("t6_no_stale", bus.out_valid, 0);
    end
    tick();

    // T6b: counter saturation, then clear colliding with a clamped handshake
    bus.in_valid = 1; bus.trend_i = 524288; bus.z_i = 0;
    repeat (65540) @(posedge clk);
    #1;
    bus.in_valid = 0;
    repeat (5) tick();
    @(negedge clk); check("t6_cnt_sat", clamp_cnt, 65535); tick();
    send(524288, 0); expect_out("t6_sat_more", 131072, 1, 0, 0, -1);
    @(negedge clk); check("t6_cnt_sticks", clamp_cnt, 65535); tick();
    send(-524288, 0);
    found = 0;
    for (k = 0; k < 10 && !found; k++) begin
      tick();
      if (bus.out_valid) begin
        found = 1;
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
      end
    end
    check("t6_clr_seen", found, 1);
    @(negedge clk); check("t6_cnt_cleared", clamp_cnt, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
